led_matrix_scanner: RTL
=======================

Name: led_matrix_scanner

Overview:
- Downstream display stage for the 8x8 snake playfield.
- Holds a double-buffered 8x8 frame: the game logic writes rows into the back buffer and requests a swap; the scanner swaps only at a frame boundary, so no frame ever shows half-updated content.
- Time-multiplexes the front buffer onto the matrix one row at a time, driving the active-low colour columns and the row-select comm bus.

Parameters:
- ROW_TICKS, 20002: clk cycles each row is displayed; must be >= 2.
- BLANK_TICKS, 16: clk cycles of blanking at the start of each row; used only with LED_SCAN_BLANK_EN; must be < ROW_TICKS.

Ports:
- clk  in  1  system clock
- clear  in  1  asynchronous active-high reset
- wr_en  in  1  write wr_data into back buffer row wr_row this cycle
- wr_row  in  3  back-buffer row address
- wr_data  in  8  row pixels; 1 = lit
- swap_req  in  1  request front/back exchange at the next frame boundary
- fg_sel  in  3  colour planes {r,g,b} that show lit pixels; sampled at frame boundary
- swap_ack  out  1  one-cycle pulse, cycle after a swap executes
- busy  out  1  swap pending
- frame_start  out  1  one-cycle pulse when row 0 begins
- comm  out  4  {enable,row[2:0]}
- data_r  out  8  red columns, active-low
- data_g  out  8  green columns, active-low
- data_b  out  8  blue columns, active-low

Behaviour:
- Reset (async, immediate):
  - both buffers = 0, tick = 0, row = 0, pending = 0.
  - Effective colour select = 3'b010 (green).
  - comm = 4'b1000; data_r/g/b = 8'hFF; swap_ack = busy = frame_start = 0.
- Tick counter:
  - Counts 0..ROW_TICKS-1.
  - At the terminal count it wraps to 0 and row increments mod 8 (7 -> 0 wraps).
- Row outputs:
  - All outputs are registered; they update on the cycle after the terminal count, together with comm.
  - comm = {1'b1,row}.
  - For each plane p in {r,g,b}: data_p = ~front[row] if the effective select bit for p is 1, else 8'hFF.
- Frame boundary: the terminal tick while row == 7.
  - frame_start = 1 on the following cycle, the first cycle of row 0.
  - fg_sel is latched into the effective select at the same boundary. A mid-frame change of fg_sel has no visible effect until the next frame.
- Writes:
  - wr_en writes wr_data into back[wr_row] on the clock edge.
  - Writes never touch the front buffer. Writing the same row twice in a frame: last write wins.
- Swap:
  - swap_req sets pending. busy = pending.
  - A request while already pending is absorbed; no second swap occurs.
  - At a frame boundary, if pending or swap_req is 1: front and back exchange (pointer flip, no copy). Pending clears and swap_ack pulses on the next cycle.
  - The new front is displayed starting at row 0 of the next frame.
  - swap_req arriving on the boundary cycle itself swaps at that boundary.
- Write on the boundary cycle when a swap executes:
  - The write lands in the pre-swap back buffer, so it becomes visible in the new front.
- After a swap, the back buffer holds the old front contents. The producer redraws before the next swap_req.
- No swap at a boundary: front keeps displaying unchanged.
- clear mid-frame: all buffered content and any pending swap are lost. Scanning restarts at row 0 with tick 0 once clear deasserts.

Optional Feature:
- Macro: LED_SCAN_BLANK_EN.
- Defined:
  - For tick < BLANK_TICKS of every row, comm[3] = 0 and data_r/g/b = 8'hFF. This removes ghosting when the row changes.
  - comm[2:0] already carries the new row during blanking.
  - Normal drive resumes at tick == BLANK_TICKS.
- Undefined:
  - No blanking; comm[3] stays 1 after reset; BLANK_TICKS is ignored.

Test Plan:
Settings: ROW_TICKS=4, BLANK_TICKS=1.
1. Reset then release, no writes -> comm steps 8,9,...,F with each row held 4 cycles. data_g = data_r = data_b = 8'hFF throughout. frame_start pulses every 32 cycles.
2. Write back[2]=8'h81, pulse swap_req mid-frame:
   - busy = 1 until the boundary, then swap_ack pulses one cycle later.
   - Next frame: data_g = 8'h7E while comm = 4'hA; all other rows 8'hFF; data_r/data_b = 8'hFF.
   - The current frame is unchanged.
3. fg_sel = 3'b101 changed mid-frame with front[0] = 8'h0F:
   - Current frame: data_g = 8'hF0 on row 0.
   - Next frame: data_r = data_b = 8'hF0, data_g = 8'hFF.
4. swap_req pulsed three times in one frame -> exactly one swap and one swap_ack. A second frame without a request -> no swap.
5. swap_req and wr_en (row 7, 8'hFF) on the boundary cycle -> swap executes; row 7 of the new front is lit (data_g = 8'h00 when comm = 4'hF).
6. clear asserted mid-row 5 -> outputs reach reset values immediately without a clock edge. After release, comm = 4'h8, and all rows show 8'hFF even after a swap.
   - With LED_SCAN_BLANK_EN, an extra check: comm[3] = 0 and data = 8'hFF for the first cycle of every row.

Source files
------------

// File: rtl/led_matrix_scanner.sv
// led_matrix_scanner: double-buffered 8x8 frame store and row scanner that
// drives the LED matrix one row at a time. Front/back buffers exchange only at
// a frame boundary, so a frame never shows half-updated content.
// Optional feature macro: LED_SCAN_BLANK_EN (blank the first BLANK_TICKS
// cycles of every row to suppress ghosting on row changes).
module led_matrix_scanner #(
    parameter int ROW_TICKS   = 20002,
    parameter int BLANK_TICKS = 16
) (
    input  logic       clk,
    input  logic       clear,
    input  logic       wr_en,
    input  logic [2:0] wr_row,
    input  logic [7:0] wr_data,
    input  logic       swap_req,
    input  logic [2:0] fg_sel,
    output logic       swap_ack,
    output logic       busy,
    output logic       frame_start,
    output logic [3:0] comm,
    output logic [7:0] data_r,
    output logic [7:0] data_g,
    output logic [7:0] data_b
);

    localparam int TICK_W = (ROW_TICKS > 1) ? $clog2(ROW_TICKS) : 1;
    localparam logic [TICK_W-1:0] TICK_LAST  = TICK_W'(ROW_TICKS - 1);
    localparam logic [TICK_W-1:0] BLANK_LAST = TICK_W'((BLANK_TICKS > 0) ? BLANK_TICKS - 1 : 0);

`ifdef LED_SCAN_BLANK_EN
    localparam bit BLANK_ON = (BLANK_TICKS > 0);
`else
    localparam bit BLANK_ON = 1'b0;
`endif

    // Two 8x8 frame stores; front_sel_q picks which one is on display.
    logic [1:0][7:0][7:0] buf_q, buf_d;
    logic                 front_sel_q, front_sel_d;
    logic [TICK_W-1:0]    tick_q, tick_d;
    logic [2:0]           row_q, row_d;
    logic                 pending_q, pending_d;
    logic [2:0]           sel_q, sel_d;
    logic                 swap_ack_q, swap_ack_d;
    logic                 frame_start_q, frame_start_d;
    logic [3:0]           comm_q, comm_d;
    logic [7:0]           data_r_q, data_r_d;
    logic [7:0]           data_g_q, data_g_d;
    logic [7:0]           data_b_q, data_b_d;

    logic                 row_end;
    logic                 frame_end;
    logic                 do_swap;
    logic                 back_sel;
    logic [7:0]           row_lit_n;

    // Next-state logic: scan counters, buffer writes, swap handshake and row drive.
    always_comb begin
        buf_d         = buf_q;
        front_sel_d   = front_sel_q;
        tick_d        = tick_q;
        row_d         = row_q;
        pending_d     = pending_q;
        sel_d         = sel_q;
        swap_ack_d    = 1'b0;
        frame_start_d = 1'b0;
        comm_d        = comm_q;
        data_r_d      = data_r_q;
        data_g_d      = data_g_q;
        data_b_d      = data_b_q;

        row_end   = (tick_q == TICK_LAST);
        frame_end = row_end && (row_q == 3'd7);
        do_swap   = frame_end && (pending_q || swap_req);
        back_sel  = ~front_sel_q;

        // The write always targets the pre-swap back buffer, so a write on the
        // swap boundary shows up in the freshly promoted front.
        if (wr_en) begin
            buf_d[back_sel][wr_row] = wr_data;
        end

        if (row_end) begin
            tick_d = '0;
            row_d  = row_q + 3'd1;
        end else begin
            tick_d = tick_q + TICK_W'(1);
        end

        if (do_swap) begin
            front_sel_d = ~front_sel_q;
            pending_d   = 1'b0;
            swap_ack_d  = 1'b1;
        end else if (swap_req) begin
            pending_d = 1'b1;
        end

        if (frame_end) begin
            sel_d         = fg_sel;
            frame_start_d = 1'b1;
        end

        // Pixels of the row that will be on display next cycle, active-low.
        row_lit_n = ~buf_d[front_sel_d][row_d];

        if (row_end) begin
            comm_d   = {1'b1, row_d};
            data_r_d = sel_d[2] ? row_lit_n : 8'hFF;
            data_g_d = sel_d[1] ? row_lit_n : 8'hFF;
            data_b_d = sel_d[0] ? row_lit_n : 8'hFF;
            if (BLANK_ON) begin
                comm_d[3] = 1'b0;
                data_r_d  = 8'hFF;
                data_g_d  = 8'hFF;
                data_b_d  = 8'hFF;
            end
        end else if (BLANK_ON && (tick_q == BLANK_LAST)) begin
            comm_d   = {1'b1, row_q};
            data_r_d = sel_q[2] ? row_lit_n : 8'hFF;
            data_g_d = sel_q[1] ? row_lit_n : 8'hFF;
            data_b_d = sel_q[0] ? row_lit_n : 8'hFF;
        end
    end

    // State and output registers; clear wipes both buffers and any pending swap.
    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            buf_q         <= '0;
            front_sel_q   <= 1'b0;
            tick_q        <= '0;
            row_q         <= 3'd0;
            pending_q     <= 1'b0;
            sel_q         <= 3'b010;
            swap_ack_q    <= 1'b0;
            frame_start_q <= 1'b0;
            comm_q        <= 4'b1000;
            data_r_q      <= 8'hFF;
            data_g_q      <= 8'hFF;
            data_b_q      <= 8'hFF;
        end else begin
            buf_q         <= buf_d;
            front_sel_q   <= front_sel_d;
            tick_q        <= tick_d;
            row_q         <= row_d;
            pending_q     <= pending_d;
            sel_q         <= sel_d;
            swap_ack_q    <= swap_ack_d;
            frame_start_q <= frame_start_d;
            comm_q        <= comm_d;
            data_r_q      <= data_r_d;
            data_g_q      <= data_g_d;
            data_b_q      <= data_b_d;
        end
    end

    assign swap_ack    = swap_ack_q;
    assign busy        = pending_q;
    assign frame_start = frame_start_q;
    assign comm        = comm_q;
    assign data_r      = data_r_q;
    assign data_g      = data_g_q;
    assign data_b      = data_b_q;

endmodule
